// File: rtl/pc_pkg.sv
// Shared constants and types for the program-counter adder slice.
package pc_pkg;

   localparam int XLEN   = 32;
   localparam int PC_INC = 4;

   typedef struct packed {
      logic carry;
      logic ovf;
      logic misalign;
   } pc_flags_t;

endpackage

// File: rtl/pc_adder_flags.sv
// Combinational sum plus carry, signed-overflow and misalignment flags.
module pc_adder_flags
   import pc_pkg::*;
#(
   parameter int WIDTH      = XLEN,
   parameter int ALIGN_BITS = 2
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] sum,
   output pc_flags_t        flags
);

   logic [WIDTH:0] full_sum;

   // One extra bit on the adder so the unsigned carry-out falls out directly.
   assign full_sum = {1'b0, a} + {1'b0, b};
   assign sum      = full_sum[WIDTH-1:0];

   assign flags = '{
      carry:    full_sum[WIDTH],
      ovf:      (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]),
      misalign: |sum[ALIGN_BITS-1:0]
   };

endmodule

// File: rtl/pc_adder.sv
// PC adder: combinational sum plus a one-cycle registered result with flags.
// Define PC_ADDER_STATS_EN to add saturating op/overflow/misalign counters.
module pc_adder
   import pc_pkg::*;
#(
   parameter int WIDTH      = XLEN,
   parameter int ALIGN_BITS = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             in_valid,
   output logic [WIDTH-1:0] c,
   output logic [WIDTH-1:0] c_q,
   output logic             out_valid,
   output logic             carry_q,
   output logic             ovf_q,
   output logic             misalign_q
`ifdef PC_ADDER_STATS_EN
   ,
   output logic [31:0]      op_count,
   output logic [15:0]      ovf_count,
   output logic [15:0]      misalign_count
`endif
);

   pc_flags_t flags;
   pc_flags_t flags_q;

   pc_adder_flags #(
      .WIDTH      (WIDTH),
      .ALIGN_BITS (ALIGN_BITS)
   ) u_flags (
      .a     (a),
      .b     (b),
      .sum   (c),
      .flags (flags)
   );

   // Result and flags only move on valid cycles, so X operands on idle cycles never reach state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         c_q       <= '0;
         flags_q   <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            c_q     <= c;
            flags_q <= flags;
         end
      end
   end

   assign carry_q    = flags_q.carry;
   assign ovf_q      = flags_q.ovf;
   assign misalign_q = flags_q.misalign;

`ifdef PC_ADDER_STATS_EN
   // Counters stick at all-ones rather than wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_count       <= '0;
         ovf_count      <= '0;
         misalign_count <= '0;
      end else if (in_valid) begin
         if (op_count != '1)
            op_count <= op_count + 32'd1;
         if (flags.ovf && ovf_count != '1)
            ovf_count <= ovf_count + 16'd1;
         if (flags.misalign && misalign_count != '1)
            misalign_count <= misalign_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_pc_adder.sv
// Self-checking bench for pc_adder using an expected-result queue.
module tb_pc_adder;

   typedef struct packed {
      logic [31:0] sum;
      logic        carry;
      logic        ovf;
      logic        misalign;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        in_valid = 1'b0;
   logic [31:0] c;
   logic [31:0] c_q;
   logic        out_valid;
   logic        carry_q;
   logic        ovf_q;
   logic        misalign_q;

   int   checks = 0;
   int   errors = 0;
   exp_t sb_queue[$];
   exp_t held = '0;

`ifdef PC_ADDER_STATS_EN
   logic [31:0] op_count;
   logic [15:0] ovf_count;
   logic [15:0] misalign_count;
   int unsigned op_m = 0;
   int unsigned ovf_m = 0;
   int unsigned mis_m = 0;
`endif

   pc_adder #(.WIDTH(32), .ALIGN_BITS(2)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .a          (a),
      .b          (b),
      .in_valid   (in_valid),
      .c          (c),
      .c_q        (c_q),
      .out_valid  (out_valid),
      .carry_q    (carry_q),
      .ovf_q      (ovf_q),
      .misalign_q (misalign_q)
`ifdef PC_ADDER_STATS_EN
      ,
      .op_count       (op_count),
      .ovf_count      (ovf_count),
      .misalign_count (misalign_count)
`endif
   );

   always #5 clk = ~clk;

   function automatic exp_t model(input logic [31:0] x, input logic [31:0] y);
      exp_t        e;
      logic [32:0] full;
      full       = {1'b0, x} + {1'b0, y};
      e.sum      = full[31:0];
      e.carry    = full[32];
      e.ovf      = (x[31] == y[31]) && (e.sum[31] != x[31]);
      e.misalign = (e.sum[1:0] != 2'b00);
      return e;
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   task automatic checkRegistered(input exp_t e, input logic v);
      checkOutput("out_valid",  64'(out_valid),  64'(v));
      checkOutput("c_q",        64'(c_q),        64'(e.sum));
      checkOutput("carry_q",    64'(carry_q),    64'(e.carry));
      checkOutput("ovf_q",      64'(ovf_q),      64'(e.ovf));
      checkOutput("misalign_q", 64'(misalign_q), 64'(e.misalign));
   endtask

   // Drive one cycle of operands, check the same-cycle sum, then the registered result.
   task automatic applyStimulus(input logic [31:0] x, input logic [31:0] y, input logic v);
      exp_t e;
      @(negedge clk);
      a = x;
      b = y;
      in_valid = v;
      e = model(x, y);
      #1;
      checkOutput("c", 64'(c), 64'(e.sum));
      if (v) begin
         sb_queue.push_back(e);
`ifdef PC_ADDER_STATS_EN
         if (op_m != 32'hFFFF_FFFF) op_m++;
         if (e.ovf && ovf_m != 16'hFFFF) ovf_m++;
         if (e.misalign && mis_m != 16'hFFFF) mis_m++;
`endif
      end
      @(posedge clk);
      #1;
      if (v) begin
         if (sb_queue.size() == 0) begin
            checkOutput("sb_empty", 64'(1), 64'(0));
         end else begin
            held = sb_queue.pop_front();
            checkRegistered(held, 1'b1);
         end
      end else begin
         checkRegistered(held, 1'b0);
      end
   endtask

   initial begin
      #1;
      checkRegistered('0, 1'b0);
      #12;
      rst_n = 1'b1;

      applyStimulus(32'h0000_0004, 32'h0000_0008, 1'b1);
      applyStimulus(32'hFFFF_FFF0, 32'hFFFF_FFF5, 1'b1);
      applyStimulus(32'h7FFF_FFFC, 32'h0000_0004, 1'b1);
      applyStimulus(32'h1234_0000, 32'h0000_0003, 1'b0);
      applyStimulus(32'h8000_0000, 32'h8000_0000, 1'b1);
      applyStimulus(32'h0000_1000, 32'h0000_0004, 1'b1);

      // Unknown operands on an idle cycle must leave the registered state alone.
      @(negedge clk);
      a = 'x;
      b = 'x;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      checkRegistered(held, 1'b0);

      for (int i = 0; i < 24; i++)
         applyStimulus($urandom, (i % 3 == 0) ? 32'(4) : $urandom, 1'($urandom_range(0, 1)));

      // Asynchronous reset between edges.
      applyStimulus(32'h0000_0010, 32'h0000_0001, 1'b1);
      @(negedge clk);
      a = 32'h0000_0020;
      b = 32'h0000_0004;
      in_valid = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      held = '0;
      checkRegistered(held, 1'b0);
      checkOutput("c_in_reset", 64'(c), 64'(32'h0000_0024));
      @(posedge clk);
      #1;
      checkRegistered(held, 1'b0);
`ifdef PC_ADDER_STATS_EN
      op_m = 0;
      ovf_m = 0;
      mis_m = 0;
      checkOutput("op_count_rst", 64'(op_count), 64'(0));
`endif
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(32'h0000_0100, 32'h0000_0004, 1'b1);
      applyStimulus(32'hFFFF_FFFF, 32'h0000_0001, 1'b1);

`ifdef PC_ADDER_STATS_EN
      applyStimulus(32'h7FFF_FFFC, 32'h0000_0004, 1'b1);
      applyStimulus(32'h0000_0000, 32'h0000_0002, 1'b1);
      checkOutput("op_count",       64'(op_count),       64'(op_m));
      checkOutput("ovf_count",      64'(ovf_count),      64'(ovf_m));
      checkOutput("misalign_count", 64'(misalign_count), 64'(mis_m));
      for (int i = 0; i < 65540; i++) begin
         @(negedge clk);
         a = 32'h7FFF_FFFC;
         b = 32'h0000_0004;
         in_valid = 1'b1;
         op_m++;
         if (ovf_m != 16'hFFFF) ovf_m++;
      end
      @(posedge clk);
      #1;
      checkOutput("ovf_count_sat", 64'(ovf_count), 64'(16'hFFFF));
      checkOutput("op_count_big",  64'(op_count),  64'(op_m));
`endif

      @(negedge clk);
      in_valid = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
